// File: rtl/ps2_entry_pkg.sv
// Shared types and scancode constants for the PS/2 message-entry controller.
package ps2_entry_pkg;

    localparam int unsigned DEPTH_DEF    = 28;
    localparam int unsigned IDX_W_DEF    = 5;
    localparam logic [7:0]  PAD_BYTE_DEF = 8'h00;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        ST_ENTRY = 3'd0,
        ST_BRK   = 3'd1,
        ST_EXT   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 make-code to ASCII translation for letters, digits and space.
module ps2_scan_to_ascii
    import ps2_entry_pkg::*;
(
    input  logic [7:0] scancode,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       printable
);

    logic [7:0] lower;
    logic       letter;

    always_comb begin
        lower     = 8'h00;
        letter    = 1'b0;
        printable = 1'b1;
        case (scancode)
            8'h1C: begin lower = 8'h61; letter = 1'b1; end
            8'h32: begin lower = 8'h62; letter = 1'b1; end
            8'h21: begin lower = 8'h63; letter = 1'b1; end
            8'h23: begin lower = 8'h64; letter = 1'b1; end
            8'h24: begin lower = 8'h65; letter = 1'b1; end
            8'h2B: begin lower = 8'h66; letter = 1'b1; end
            8'h34: begin lower = 8'h67; letter = 1'b1; end
            8'h33: begin lower = 8'h68; letter = 1'b1; end
            8'h43: begin lower = 8'h69; letter = 1'b1; end
            8'h3B: begin lower = 8'h6A; letter = 1'b1; end
            8'h42: begin lower = 8'h6B; letter = 1'b1; end
            8'h4B: begin lower = 8'h6C; letter = 1'b1; end
            8'h3A: begin lower = 8'h6D; letter = 1'b1; end
            8'h31: begin lower = 8'h6E; letter = 1'b1; end
            8'h44: begin lower = 8'h6F; letter = 1'b1; end
            8'h4D: begin lower = 8'h70; letter = 1'b1; end
            8'h15: begin lower = 8'h71; letter = 1'b1; end
            8'h2D: begin lower = 8'h72; letter = 1'b1; end
            8'h1B: begin lower = 8'h73; letter = 1'b1; end
            8'h2C: begin lower = 8'h74; letter = 1'b1; end
            8'h3C: begin lower = 8'h75; letter = 1'b1; end
            8'h2A: begin lower = 8'h76; letter = 1'b1; end
            8'h1D: begin lower = 8'h77; letter = 1'b1; end
            8'h22: begin lower = 8'h78; letter = 1'b1; end
            8'h35: begin lower = 8'h79; letter = 1'b1; end
            8'h1A: begin lower = 8'h7A; letter = 1'b1; end
            8'h45: lower = 8'h30;
            8'h16: lower = 8'h31;
            8'h1E: lower = 8'h32;
            8'h26: lower = 8'h33;
            8'h25: lower = 8'h34;
            8'h2E: lower = 8'h35;
            8'h36: lower = 8'h36;
            8'h3D: lower = 8'h37;
            8'h3E: lower = 8'h38;
            8'h46: lower = 8'h39;
            8'h29: lower = 8'h20;
            default: printable = 1'b0;
        endcase
    end

    // Lowercase and uppercase ASCII letters differ only in bit 5.
    assign ascii = (shift && letter) ? (lower & 8'hDF) : lower;

endmodule

// File: rtl/ps2_entry_ctrl.sv
// PS/2 scancode to datastore write-port controller with Enter/Backspace/Escape handling.
// Optional feature macro: ENTRY_SHIFT_EN (shift-key tracking for uppercase letters).
module ps2_entry_ctrl
    import ps2_entry_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter logic [7:0]  PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       scan_byte,
    input  logic             scan_valid,
    output logic [7:0]       ds_data,
    output logic [IDX_W-1:0] ds_index,
    output logic             ds_we,
    output logic [IDX_W-1:0] msg_len,
    output logic             msg_done,
    output logic             busy,
    output logic             overflow
);

    localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_L   = IDX_W'(1);

    state_e           state_q,    state_d;
    logic [IDX_W-1:0] len_q,      len_d;
    logic [IDX_W-1:0] sweep_q,    sweep_d;
    logic [7:0]       ds_data_q,  ds_data_d;
    logic [IDX_W-1:0] ds_index_q, ds_index_d;
    logic             ds_we_q,    ds_we_d;
    logic             done_q,     done_d;
    logic             busy_q,     busy_d;
    logic             ovf_q,      ovf_d;
    logic             shift_q,    shift_d;

    logic [7:0]       xl_ascii;
    logic             xl_printable;
    state_e           home_st;
    logic             wr_ok;

    ps2_scan_to_ascii u_xlat (
        .scancode  (scan_byte),
        .shift     (shift_q),
        .ascii     (xl_ascii),
        .printable (xl_printable)
    );

    // BRK/EXT fall back to DONE when the message is frozen, otherwise to ENTRY.
    assign home_st = done_q ? ST_DONE : ST_ENTRY;
    // A write landing right after another is dropped so strobes are never back to back.
    assign wr_ok   = !ds_we_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sweep_d    = sweep_q;
        ds_data_d  = ds_data_q;
        ds_index_d = ds_index_q;
        ds_we_d    = 1'b0;
        done_d     = done_q;
        busy_d     = 1'b0;
        ovf_d      = ovf_q;
        shift_d    = shift_q;

        if (state_q == ST_CLEAR) begin
            ds_we_d    = 1'b1;
            ds_data_d  = PAD_BYTE;
            ds_index_d = sweep_q;
            busy_d     = 1'b1;
            sweep_d    = sweep_q + ONE_L;
            if (sweep_q == LAST_L) begin
                state_d = ST_ENTRY;
            end
        end else if (scan_valid) begin
            if (scan_byte == SC_ESC) begin
                // First sweep pulse (index 0) issues on the Escape edge itself.
                state_d    = ST_CLEAR;
                ds_we_d    = 1'b1;
                ds_data_d  = PAD_BYTE;
                ds_index_d = '0;
                sweep_d    = ONE_L;
                busy_d     = 1'b1;
                len_d      = '0;
                done_d     = 1'b0;
                ovf_d      = 1'b0;
            end else begin
                case (state_q)
                    ST_ENTRY: begin
                        if (scan_byte == SC_BREAK) begin
                            state_d = ST_BRK;
                        end else if (scan_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (xl_printable) begin
                            if (len_q == DEPTH_L) begin
                                ovf_d = 1'b1;
                            end else if (wr_ok) begin
                                ds_we_d    = 1'b1;
                                ds_data_d  = xl_ascii;
                                ds_index_d = len_q;
                                len_d      = len_q + ONE_L;
                            end
                        end else if (scan_byte == SC_BKSP) begin
                            if ((len_q != '0) && wr_ok) begin
                                ds_we_d    = 1'b1;
                                ds_data_d  = PAD_BYTE;
                                ds_index_d = len_q - ONE_L;
                                len_d      = len_q - ONE_L;
                            end
                        end else if (scan_byte == SC_ENTER) begin
                            if (len_q != '0) begin
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end
                        end else begin
`ifdef ENTRY_SHIFT_EN
                            if (is_shift_code(scan_byte)) begin
                                shift_d = 1'b1;
                            end
`endif
                        end
                    end
                    ST_DONE: begin
                        if (scan_byte == SC_BREAK) begin
                            state_d = ST_BRK;
                        end else if (scan_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else begin
`ifdef ENTRY_SHIFT_EN
                            if (is_shift_code(scan_byte)) begin
                                shift_d = 1'b1;
                            end
`endif
                        end
                    end
                    ST_BRK: begin
`ifdef ENTRY_SHIFT_EN
                        if (is_shift_code(scan_byte)) begin
                            shift_d = 1'b0;
                        end
`endif
                        state_d = home_st;
                    end
                    ST_EXT: begin
                        state_d = (scan_byte == SC_BREAK) ? ST_BRK : home_st;
                    end
                    default: state_d = ST_ENTRY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_ENTRY;
            len_q      <= '0;
            sweep_q    <= '0;
            ds_data_q  <= '0;
            ds_index_q <= '0;
            ds_we_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sweep_q    <= sweep_d;
            ds_data_q  <= ds_data_d;
            ds_index_q <= ds_index_d;
            ds_we_q    <= ds_we_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            shift_q    <= shift_d;
        end
    end

    assign ds_data  = ds_data_q;
    assign ds_index = ds_index_q;
    assign ds_we    = ds_we_q;
    assign msg_len  = len_q;
    assign msg_done = done_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// Directed self-checking bench for ps2_entry_ctrl; honours ENTRY_SHIFT_EN when defined.
module tb_ps2_entry_ctrl;

    logic       clk;
    logic       resetn;
    logic [7:0] scan_byte;
    logic       scan_valid;
    logic [7:0] ds_data;
    logic [4:0] ds_index;
    logic       ds_we;
    logic [4:0] msg_len;
    logic       msg_done;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // write log filled by the monitor only
    logic [4:0] log_idx [256];
    logic [7:0] log_dat [256];
    int         wr_cnt   = 0;
    int         busy_cnt = 0;

    ps2_entry_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .scan_byte  (scan_byte),
        .scan_valid (scan_valid),
        .ds_data    (ds_data),
        .ds_index   (ds_index),
        .ds_we      (ds_we),
        .msg_len    (msg_len),
        .msg_done   (msg_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #2;
        if (ds_we === 1'b1) begin
            log_idx[wr_cnt % 256] = ds_index;
            log_dat[wr_cnt % 256] = ds_data;
            wr_cnt = wr_cnt + 1;
        end
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // one-cycle strobe followed by one idle cycle; call at a negedge
    task automatic send(input logic [7:0] b);
        scan_byte  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        #2;
        checks++;
        if ({ds_we, ds_data, ds_index, msg_len, msg_done, busy, overflow} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000000",
                     {ds_we, ds_data, ds_index, msg_len, msg_done, busy, overflow});
        end
        idle(2);
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_single();
        int base;
        base = wr_cnt;
        scan_byte  = 8'h1C;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        checks++;
        if ({ds_we, ds_data, ds_index} !== {1'b1, 8'h61, 5'd0}) begin
            errors++;
            $display("FAIL single_write: got we=%b data=%h idx=%0d expected we=1 data=61 idx=0",
                     ds_we, ds_data, ds_index);
        end
        checks++;
        if (msg_len !== 5'd1) begin
            errors++;
            $display("FAIL single_len: got %0d expected 1", msg_len);
        end
        @(negedge clk);
        checks++;
        if ({ds_we, ds_data, ds_index} !== {1'b0, 8'h61, 5'd0}) begin
            errors++;
            $display("FAIL single_hold: got we=%b data=%h idx=%0d expected we=0 data=61 idx=0",
                     ds_we, ds_data, ds_index);
        end
        checks++;
        if (wr_cnt - base !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes expected 1", wr_cnt - base);
        end
    endtask

    task automatic test_break();
        int base;
        do_reset();
        base = wr_cnt;
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32);
        checks++;
        if (wr_cnt - base !== 2) begin
            errors++;
            $display("FAIL break_count: got %0d writes expected 2", wr_cnt - base);
        end
        checks++;
        if ({log_idx[base % 256], log_dat[base % 256], log_idx[(base + 1) % 256], log_dat[(base + 1) % 256]}
            !== {5'd0, 8'h61, 5'd1, 8'h62}) begin
            errors++;
            $display("FAIL break_writes: got (%0d,%h) (%0d,%h) expected (0,61) (1,62)",
                     log_idx[base % 256], log_dat[base % 256],
                     log_idx[(base + 1) % 256], log_dat[(base + 1) % 256]);
        end
        checks++;
        if (msg_len !== 5'd2) begin
            errors++;
            $display("FAIL break_len: got %0d expected 2", msg_len);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = wr_cnt;
        for (int k = 0; k < 28; k++) send(8'h1C);
        checks++;
        if (wr_cnt - base !== 28) begin
            errors++;
            $display("FAIL full_count: got %0d writes expected 28", wr_cnt - base);
        end
        for (int k = 0; k < 28; k++) begin
            checks++;
            if ({log_idx[(base + k) % 256], log_dat[(base + k) % 256]} !== {5'(k), 8'h61}) begin
                errors++;
                $display("FAIL full_write_%0d: got (%0d,%h) expected (%0d,61)", k,
                         log_idx[(base + k) % 256], log_dat[(base + k) % 256], k);
            end
        end
        checks++;
        if ({msg_len, overflow} !== {5'd28, 1'b0}) begin
            errors++;
            $display("FAIL full_state: got len=%0d ovf=%b expected len=28 ovf=0", msg_len, overflow);
        end
        base = wr_cnt;
        send(8'h1C);
        checks++;
        if ({wr_cnt - base, msg_len, overflow} !== {32'd0, 5'd28, 1'b1}) begin
            errors++;
            $display("FAIL overflow: got writes=%0d len=%0d ovf=%b expected writes=0 len=28 ovf=1",
                     wr_cnt - base, msg_len, overflow);
        end
        base = wr_cnt;
        send(8'h66);
        checks++;
        if ({wr_cnt - base, log_idx[base % 256], log_dat[base % 256], msg_len}
            !== {32'd1, 5'd27, 8'h00, 5'd27}) begin
            errors++;
            $display("FAIL bksp_full: got writes=%0d (%0d,%h) len=%0d expected writes=1 (27,00) len=27",
                     wr_cnt - base, log_idx[base % 256], log_dat[base % 256], msg_len);
        end
    endtask

    task automatic test_done_clear();
        int base;
        int bbase;
        do_reset();
        base = wr_cnt;
        send(8'h45); send(8'h5A); send(8'h16);
        checks++;
        if ({wr_cnt - base, log_idx[base % 256], log_dat[base % 256]} !== {32'd1, 5'd0, 8'h30}) begin
            errors++;
            $display("FAIL done_writes: got writes=%0d (%0d,%h) expected writes=1 (0,30)",
                     wr_cnt - base, log_idx[base % 256], log_dat[base % 256]);
        end
        checks++;
        if ({msg_done, msg_len} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL done_state: got done=%b len=%0d expected done=1 len=1", msg_done, msg_len);
        end
        base  = wr_cnt;
        bbase = busy_cnt;
        send(8'h76);
        checks++;
        if ({busy, msg_done, msg_len} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL clear_entry: got busy=%b done=%b len=%0d expected busy=1 done=0 len=0",
                     busy, msg_done, msg_len);
        end
        idle(35);
        checks++;
        if ({wr_cnt - base, busy_cnt - bbase, busy} !== {32'd28, 32'd28, 1'b0}) begin
            errors++;
            $display("FAIL clear_counts: got writes=%0d busy_cycles=%0d busy=%b expected 28 28 0",
                     wr_cnt - base, busy_cnt - bbase, busy);
        end
        for (int k = 0; k < 28; k++) begin
            checks++;
            if ({log_idx[(base + k) % 256], log_dat[(base + k) % 256]} !== {5'(k), 8'h00}) begin
                errors++;
                $display("FAIL clear_write_%0d: got (%0d,%h) expected (%0d,00)", k,
                         log_idx[(base + k) % 256], log_dat[(base + k) % 256], k);
            end
        end
        base = wr_cnt;
        send(8'h1C);
        checks++;
        if ({wr_cnt - base, log_idx[base % 256], log_dat[base % 256], msg_len}
            !== {32'd1, 5'd0, 8'h61, 5'd1}) begin
            errors++;
            $display("FAIL after_clear: got writes=%0d (%0d,%h) len=%0d expected 1 (0,61) len=1",
                     wr_cnt - base, log_idx[base % 256], log_dat[base % 256], msg_len);
        end
    endtask

    task automatic test_len0();
        int base;
        do_reset();
        base = wr_cnt;
        send(8'h66); send(8'h5A);
        checks++;
        if ({wr_cnt - base, msg_done, msg_len} !== {32'd0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL len0_keys: got writes=%0d done=%b len=%0d expected 0 0 0",
                     wr_cnt - base, msg_done, msg_len);
        end
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        checks++;
        if (wr_cnt - base !== 0) begin
            errors++;
            $display("FAIL ext_discard: got %0d writes expected 0", wr_cnt - base);
        end
        send(8'h29);
        checks++;
        if ({wr_cnt - base, log_idx[base % 256], log_dat[base % 256]} !== {32'd1, 5'd0, 8'h20}) begin
            errors++;
            $display("FAIL ext_return: got writes=%0d (%0d,%h) expected 1 (0,20)",
                     wr_cnt - base, log_idx[base % 256], log_dat[base % 256]);
        end
    endtask

    task automatic test_shift();
        int         base;
        logic [7:0] exp_first;
`ifdef ENTRY_SHIFT_EN
        exp_first = 8'h41;
`else
        exp_first = 8'h61;
`endif
        do_reset();
        base = wr_cnt;
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        checks++;
        if ({wr_cnt - base, log_dat[base % 256], log_dat[(base + 1) % 256]}
            !== {32'd2, exp_first, 8'h61}) begin
            errors++;
            $display("FAIL shift_writes: got writes=%0d %h %h expected 2 %h 61",
                     wr_cnt - base, log_dat[base % 256], log_dat[(base + 1) % 256], exp_first);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int base;
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h76);
        idle(5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sweep_busy: got %b expected 1", busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({ds_we, ds_data, ds_index, msg_len, msg_done, busy, overflow} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 000000",
                     {ds_we, ds_data, ds_index, msg_len, msg_done, busy, overflow});
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        send(8'h1C);
        checks++;
        if ({wr_cnt - base, log_idx[base % 256], log_dat[base % 256], busy}
            !== {32'd1, 5'd0, 8'h61, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: got writes=%0d (%0d,%h) busy=%b expected 1 (0,61) 0",
                     wr_cnt - base, log_idx[base % 256], log_dat[base % 256], busy);
        end
    endtask

    initial begin
        resetn     = 1'b1;
        scan_byte  = 8'h00;
        scan_valid = 1'b0;
        test_reset();
        test_single();
        test_break();
        test_overflow();
        test_done_clear();
        test_len0();
        test_shift();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
